// File: rtl/parking_pkg.sv
// ============================================================================
// Module      : parking_pkg
// Description : Shared types and default constants for the car park barrier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    OPEN_IN  = 2'b01,
    OPEN_OUT = 2'b10,
    CLOSING  = 2'b11
  } state_t;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  localparam int CAPACITY_DEF  = 16;
  localparam int CNT_W_DEF     = 5;
  localparam int TIMEOUT_DEF   = 100;
  localparam int CLOSE_CYC_DEF = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_timer.sv
// ============================================================================
// Module      : gate_timer
// Description : Loadable down-counter; done is high during the value-th cycle
//               after a load and stays high until the next load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] r_cnt;

  // Storing value-1 makes a load of N span exactly N cycles up to done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= (value == '0) ? '0 : value - W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
// ============================================================================
// Module      : parking_gate_arbiter
// Description : Entry/exit arbiter and occupancy tracker for a single-lane
//               bidirectional barrier. Define PARKING_STATS_EN to add the
//               total_in/total_out passage counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY  = CAPACITY_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int CLOSE_CYC = CLOSE_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_in,
  input  logic             car_out,
  output logic             gate_open,
  output logic             dir_in,
  output logic             grant_in,
  output logic             grant_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             timeout_err,
  output logic             cnt_err
`ifdef PARKING_STATS_EN
  ,
  output logic [15:0]      total_in,
  output logic [15:0]      total_out
`endif
);

  localparam int             TMR_W = $clog2(max_int(TIMEOUT, CLOSE_CYC) + 1);
  localparam logic [CNT_W-1:0] C_CAP = CNT_W'(CAPACITY);

  state_t             r_state, w_state_nxt;
  logic               r_last_served;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic               r_gate_open, r_dir_in, r_grant_in, r_grant_out;
  logic               r_timeout_err, r_cnt_err;
  logic               w_tmr_load, w_tmr_done;
  logic [TMR_W-1:0]   w_tmr_value;
  logic               w_full, w_empty, w_entry_ok, w_exit_ok;
  logic               w_grant_in, w_grant_out, w_timeout, w_cnt_err;
  logic               w_in_only, w_out_only;

  assign w_full     = (r_count == C_CAP);
  assign w_empty    = (r_count == '0);
  assign w_entry_ok = entry_req && !w_full;
  assign w_exit_ok  = exit_req && !w_empty;
  assign w_in_only  = car_in && !car_out;
  assign w_out_only = car_out && !car_in;

  gate_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (w_tmr_load),
    .value (w_tmr_value),
    .done  (w_tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_last_served <= DIR_OUT;
      r_count       <= '0;
      r_gate_open   <= 1'b0;
      r_dir_in      <= 1'b0;
      r_grant_in    <= 1'b0;
      r_grant_out   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_gate_open   <= (w_state_nxt == OPEN_IN) || (w_state_nxt == OPEN_OUT);
      r_dir_in      <= (w_state_nxt == OPEN_IN);
      r_grant_in    <= w_grant_in;
      r_grant_out   <= w_grant_out;
      r_timeout_err <= w_timeout;
      r_cnt_err     <= w_cnt_err;
      if (w_grant_in) begin
        r_last_served <= DIR_IN;
      end else if (w_grant_out) begin
        r_last_served <= DIR_OUT;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_value = TMR_W'(TIMEOUT);
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie, serve the direction that was not served last.
        if (w_entry_ok && (!w_exit_ok || r_last_served == DIR_OUT)) begin
          w_state_nxt = OPEN_IN;
          w_tmr_load  = 1'b1;
        end else if (w_exit_ok) begin
          w_state_nxt = OPEN_OUT;
          w_tmr_load  = 1'b1;
        end
      end
      OPEN_IN, OPEN_OUT: begin
        if ((r_state == OPEN_IN) ? car_in : car_out) begin
          w_state_nxt = CLOSING;
          w_tmr_load  = 1'b1;
          w_tmr_value = TMR_W'(CLOSE_CYC);
        end else if (w_tmr_done) begin
          w_state_nxt = CLOSING;
          w_tmr_load  = 1'b1;
          w_tmr_value = TMR_W'(CLOSE_CYC);
          w_timeout   = 1'b1;
        end
      end
      CLOSING: begin
        if (w_tmr_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_grant_in  = (r_state == IDLE) && (w_state_nxt == OPEN_IN);
    w_grant_out = (r_state == IDLE) && (w_state_nxt == OPEN_OUT);
    w_count_nxt = r_count;
    w_cnt_err   = 1'b0;
    // Sensors are trusted in every state; unexpected passages only flag.
    if (w_in_only) begin
      if (w_full) w_cnt_err = 1'b1;
      else        w_count_nxt = r_count + CNT_W'(1);
      if (r_state != OPEN_IN) w_cnt_err = 1'b1;
    end
    if (w_out_only) begin
      if (w_empty) w_cnt_err = 1'b1;
      else         w_count_nxt = r_count - CNT_W'(1);
      if (r_state != OPEN_OUT) w_cnt_err = 1'b1;
    end
  end

  assign gate_open   = r_gate_open;
  assign dir_in      = r_dir_in;
  assign grant_in    = r_grant_in;
  assign grant_out   = r_grant_out;
  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign timeout_err = r_timeout_err;
  assign cnt_err     = r_cnt_err;

`ifdef PARKING_STATS_EN
  logic [15:0] r_total_in, r_total_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_total_in  <= '0;
      r_total_out <= '0;
    end else begin
      if (car_in)  r_total_in  <= r_total_in + 16'd1;
      if (car_out) r_total_out <= r_total_out + 16'd1;
    end
  end

  assign total_in  = r_total_in;
  assign total_out = r_total_out;
`endif

endmodule

`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
// ============================================================================
// Module      : tb_parking_gate_arbiter
// Description : Directed scoreboard bench for parking_gate_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_gate_arbiter;

  localparam int K_GI = 0, K_GO = 1, K_TO = 2, K_CE = 3;

  typedef struct {
    int kind;
    int cyc;
    int count;
  } ev_t;

  logic       clk, reset, entry_req, exit_req, car_in, car_out;
  logic       gate_open, dir_in, grant_in, grant_out, full, empty;
  logic       timeout_err, cnt_err;
  logic [4:0] count;
`ifdef PARKING_STATS_EN
  logic [15:0] total_in, total_out;
`endif

  ev_t   sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc;
  int    m_count;
  string knames[4] = '{"grant_in", "grant_out", "timeout_err", "cnt_err"};

  parking_gate_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .car_in      (car_in),
    .car_out     (car_out),
    .gate_open   (gate_open),
    .dir_in      (dir_in),
    .grant_in    (grant_in),
    .grant_out   (grant_out),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .timeout_err (timeout_err),
    .cnt_err     (cnt_err)
`ifdef PARKING_STATS_EN
    ,
    .total_in    (total_in),
    .total_out   (total_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int kind, input int dc);
    ev_t e;
    e.kind  = kind;
    e.cyc   = cyc + dc;
    e.count = m_count;
    sb.push_back(e);
  endtask

  // Unauthorised entry while IDLE: counts up and must flag cnt_err.
  task automatic tailgate_in();
    car_in = 1'b1;
    m_count++;
    expect_ev(K_CE, 1);
    step();
    car_in = 1'b0;
    step();
  endtask

  // Monitor: every pulse output pops one expectation from the scoreboard.
  always @(negedge clk) begin
    logic [3:0] p;
    ev_t        e;
    if (reset) begin
      p = {cnt_err, timeout_err, grant_out, grant_in};
      for (int k = 0; k < 4; k++) begin
        if (p[k]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s at cycle %0d: actual=1 required=0", knames[k], cyc);
          end else begin
            e = sb.pop_front();
            chk({"ev_kind_", knames[k]}, k, e.kind);
            chk({"ev_cycle_", knames[k]}, cyc, e.cyc);
            chk({"ev_count_", knames[k]}, int'(count), e.count);
            if (k < 2) begin
              chk("grant_gate_open", int'(gate_open), 1);
              chk("grant_dir_in", int'(dir_in), (k == K_GI) ? 1 : 0);
            end
            if (k == K_TO) chk("timeout_gate_open", int'(gate_open), 0);
          end
        end
      end
    end
  end

  initial begin
    int c0, g, t, u, w;
    reset = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
    car_in = 1'b0; car_out = 1'b0; m_count = 0;

    #12;
    chk("rst_gate_open", int'(gate_open), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_dir_in", int'(dir_in), 0);
    chk("rst_pulses", int'({grant_in, grant_out, timeout_err, cnt_err}), 0);
    reset = 1'b1;
    step(3);

    // Entry grant, passage, closing interval; a request held through CLOSING
    // is granted the cycle after IDLE is reached.
    c0 = cyc;
    entry_req = 1'b1;
    expect_ev(K_GI, 1);
    step();
    chk("t1_gate_open", int'(gate_open), 1);
    chk("t1_dir_in", int'(dir_in), 1);
    entry_req = 1'b0;
    step(14);
    car_in = 1'b1;
    m_count++;
    step();
    car_in = 1'b0;
    chk("t1_count", int'(count), 1);
    chk("t1_closed", int'(gate_open), 0);
    step();
    entry_req = 1'b1;
    sb.push_back('{K_GI, c0 + 27, 1});
    step(8);
    chk("t1_still_closed", int'(gate_open), 0);
    step(2);
    entry_req = 1'b0;
    g = cyc;
    chk("t1_reopen", int'(gate_open), 1);

    // Open window expires without a passage.
    sb.push_back('{K_TO, g + 100, 1});
    step(100);
    chk("t4_gate_open", int'(gate_open), 0);
    chk("t4_count", int'(count), 1);
    step(10);

    // Tie with last_served = entry goes to exit first, then entry.
    tailgate_in();
    tailgate_in();
    t = cyc;
    entry_req = 1'b1;
    exit_req  = 1'b1;
    expect_ev(K_GO, 1);
    step(5);
    car_out = 1'b1;
    m_count--;
    step();
    car_out = 1'b0;
    chk("t2_count", int'(count), 2);
    sb.push_back('{K_GI, t + 17, 2});
    step(11);
    chk("t2_dir_in", int'(dir_in), 1);
    entry_req = 1'b0;
    exit_req  = 1'b0;
    car_in = 1'b1;
    m_count++;
    step();
    car_in = 1'b0;
    step(11);

    // Fill to capacity, then overflow attempt.
    while (m_count < 16) tailgate_in();
    chk("t3_full", int'(full), 1);
    car_in = 1'b1;
    expect_ev(K_CE, 1);
    step();
    car_in = 1'b0;
    step();
    chk("t3_overflow_count", int'(count), 16);
    entry_req = 1'b1;
    step(20);
    u = cyc;
    exit_req = 1'b1;
    expect_ev(K_GO, 1);
    step();
    exit_req = 1'b0;
    step();
    car_out = 1'b1;
    m_count--;
    sb.push_back('{K_GI, u + 14, 15});
    step();
    car_out = 1'b0;
    chk("t3_count", int'(count), 15);
    chk("t3_not_full", int'(full), 0);
    step(11);
    entry_req = 1'b0;
    car_in = 1'b1;
    m_count++;
    step();
    car_in = 1'b0;
    step(11);

    // Asynchronous reset while open for exit.
    w = cyc;
    exit_req = 1'b1;
    expect_ev(K_GO, 1);
    step();
    exit_req = 1'b0;
    step(2);
    chk("t6_open_before_reset", int'(gate_open), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_gate_open", int'(gate_open), 0);
    chk("t6_count", int'(count), 0);
    chk("t6_empty", int'(empty), 1);
    m_count = 0;
    @(negedge clk);
    reset = 1'b1;
    step(2);

    // Exit is not eligible while empty.
    exit_req = 1'b1;
    step(5);
    exit_req = 1'b0;
    step();

    // Underflow, then simultaneous in/out at count 5.
    car_out = 1'b1;
    expect_ev(K_CE, 1);
    step();
    car_out = 1'b0;
    step();
    chk("t5_underflow_count", int'(count), 0);
    repeat (5) tailgate_in();
    car_in  = 1'b1;
    car_out = 1'b1;
    step();
    car_in  = 1'b0;
    car_out = 1'b0;
    chk("t5_both_count", int'(count), 5);
    chk("t5_not_empty", int'(empty), 0);
    step(3);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d: actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/parking_gate_arbiter.md
Name: parking_gate_arbiter

Overview:
- Controls a single-lane bidirectional barrier at the car park entrance.
- Arbitrates entry and exit requests for the one shared gate and tracks occupancy from the car_in/car_out pulses of the sensor FSM.
- Each completed or timed-out passage is followed by a fixed closing interval.
- Sits between the request buttons/ticket readers, the sensor FSM and the barrier motor driver.

Parameters:
- CAPACITY, 16, maximum number of parked cars.
- CNT_W, 5, occupancy counter width; must satisfy 2^CNT_W > CAPACITY.
- TIMEOUT, 100, cycles the gate stays open waiting for a passage.
- CLOSE_CYC, 10, cycles spent in the closing phase before new grants.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- entry_req  in  1  level; a car is requesting entry.
- exit_req  in  1  level; a car is requesting exit.
- car_in  in  1  one-cycle pulse; the sensor FSM confirmed an entry.
- car_out  in  1  one-cycle pulse; the sensor FSM confirmed an exit.
- gate_open  out  1  barrier command; 1 = raise.
- dir_in  out  1  direction being served; 1 = entry, 0 = exit; valid while gate_open=1.
- grant_in  out  1  one-cycle pulse when an entry is granted.
- grant_out  out  1  one-cycle pulse when an exit is granted.
- count  out  CNT_W  current occupancy.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- timeout_err  out  1  one-cycle pulse when an open window expires without a passage.
- cnt_err  out  1  one-cycle pulse on occupancy overflow, occupancy underflow or a wrong-direction passage.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, last_served=EXIT.
  - All outputs are 0 except empty=1.
  - Asserting reset mid-operation drops gate_open immediately.
- All outputs are registered; full and empty are decoded from the registered count.
- State machine with states IDLE, OPEN_IN, OPEN_OUT and CLOSING:
  - IDLE: entry_req is eligible only if !full; exit_req is eligible only if !empty.
  - IDLE, only one eligible request: go to the matching OPEN state.
  - IDLE, both eligible in the same cycle: grant the direction opposite to last_served, so the first tie after reset goes to entry.
  - Grant latency: a request sampled in cycle N gives state, gate_open=1, dir_in and the grant pulse in cycle N+1. last_served is updated on grant.
  - OPEN_IN: a car_in pulse goes to CLOSING. If TIMEOUT cycles elapse with no car_in, go to CLOSING and pulse timeout_err.
  - OPEN_OUT: same as OPEN_IN, using car_out.
  - CLOSING: gate_open=0 for exactly CLOSE_CYC cycles, then IDLE. Requests are ignored and not queued; a level still held is re-evaluated in IDLE.
- Occupancy is updated in every state, because the sensors are authoritative:
  - car_in alone: count+1. At CAPACITY, count holds and cnt_err pulses.
  - car_out alone: count-1. At 0, count holds and cnt_err pulses.
  - car_in and car_out in the same cycle: count unchanged, no error.
  - car_out during OPEN_IN, or car_in during OPEN_OUT: count is still updated and cnt_err pulses; the state stays open.
  - car_in or car_out in IDLE or CLOSING (tailgating): count is updated and cnt_err pulses.
- Timer:
  - Loaded on entry to an OPEN state (TIMEOUT) and on entry to CLOSING (CLOSE_CYC).
  - Counts down one per cycle; done fires at 0.
  - A passage pulse in the same cycle as done takes priority, so no timeout_err is raised.

Optional Feature:
- Macro: PARKING_STATS_EN.
- Defined: adds output ports total_in[15:0] and total_out[15:0].
  - They increment on every car_in and car_out pulse respectively, including error cases.
  - They wrap from 0xFFFF to 0 and are cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package parking_pkg:
  - state enum (IDLE=2'b00, OPEN_IN=2'b01, OPEN_OUT=2'b10, CLOSING=2'b11)
  - direction constants DIR_IN=1, DIR_OUT=0
  - default CAPACITY/TIMEOUT/CLOSE_CYC constants
- One sub-module, gate_timer: load/value inputs, down-counter, done output. It is reused by future barrier blocks.
- Occupancy counter and arbiter stay in the top module.

Test Plan:
- Reset, then entry_req=1 at cycle 5 → grant_in and gate_open=1, dir_in=1 at cycle 6; car_in at cycle 20 → count=1, gate_open=0 from cycle 21 for 10 cycles, then IDLE.
- count=3, last_served=IN, entry_req and exit_req both held → exit granted first; after the passage and CLOSING, entry is granted next.
- count=16 (full), entry_req held → no grant_in ever; exit_req → grant_out, and after car_out, count=15 and full=0.
- Gate opened for entry, no car_in for 100 cycles → timeout_err pulse, CLOSING, count unchanged.
- car_out with count=0 → cnt_err pulse, count stays 0. car_in and car_out in the same cycle with count=5 → count=5, no cnt_err.
- reset driven low while gate_open=1 in OPEN_OUT → gate_open=0 and count=0 asynchronously, before the next clk edge.
